// File: rtl/sw_pkg.sv
// Shared switch-path constants, also used by the priority-encoder/segment stage.
package sw_pkg;
    localparam int SW_W      = 9;
    localparam int DB_CYCLES = 20000;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;
endpackage

// File: rtl/sw_debounce_if.sv
// Switch bundle between the board pins and the debounced consumers.
interface sw_debounce_if #(
    parameter int SW_W = sw_pkg::SW_W
);
    import sw_pkg::*;

    logic [SW_W-1:0] sw_raw;
    logic [SW_W-1:0] sw;
    logic [SW_W-1:0] sw_rise;
    logic [SW_W-1:0] sw_fall;
    logic            sw_changed;

    modport master (output sw_raw, input sw, sw_rise, sw_fall, sw_changed);
    modport slave  (input sw_raw, output sw, sw_rise, sw_fall, sw_changed);
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch: two-flop synchronizer, stability counter, accepted level and edge pulses.
module sw_debounce_bit #(
    parameter int DB_CYCLES = sw_pkg::DB_CYCLES,
    parameter int CNT_W     = sw_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stb,
    output logic o_rise,
    output logic o_fall
);
    import sw_pkg::*;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stb;
    logic             r_rise;
    logic             r_fall;

    logic  w_diff;
    logic  w_done;
    edge_e w_edge;

    // The flip happens on the DB_CYCLES-th consecutive mismatching edge, so the
    // counter tops out at DB_CYCLES-1 and can never wrap.
    always_comb begin
        w_diff = r_sync2 ^ r_stb;
        w_done = w_diff && (r_cnt == LP_LAST);
        w_edge = EDGE_NONE;
        if (w_done) begin
            w_edge = r_sync2 ? EDGE_RISE : EDGE_FALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_stb   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_diff || w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done) begin
                r_stb <= r_sync2;
            end
            r_rise <= (w_edge == EDGE_RISE);
            r_fall <= (w_edge == EDGE_FALL);
        end
    end

    assign o_stb  = r_stb;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule

// File: rtl/sw_debounce.sv
// Debounces SW_W independent board switches; sw_changed flags any accepted flip.
module sw_debounce #(
    parameter int SW_W      = sw_pkg::SW_W,
    parameter int DB_CYCLES = sw_pkg::DB_CYCLES,
    parameter int CNT_W     = sw_pkg::CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    sw_debounce_if.slave  bus
);
    import sw_pkg::*;

    logic [SW_W-1:0] w_stb;
    logic [SW_W-1:0] w_rise;
    logic [SW_W-1:0] w_fall;

    for (genvar g = 0; g < SW_W; g++) begin : g_bit
        sw_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (bus.sw_raw[g]),
            .o_stb  (w_stb[g]),
            .o_rise (w_rise[g]),
            .o_fall (w_fall[g])
        );
    end

    assign bus.sw         = w_stb;
    assign bus.sw_rise    = w_rise;
    assign bus.sw_fall    = w_fall;
    // Both inputs are registered, so this pulse is glitch-free and one cycle wide.
    assign bus.sw_changed = |(w_rise | w_fall);
endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter: SW_W, 9, number of switch inputs.
REQ-002 Parameter: DB_CYCLES, 20000, consecutive stable cycles required to accept a new level; legal range 2..65535.
REQ-003 Parameter: CNT_W, 16, width of each per-bit stability counter; SHALL satisfy 2**CNT_W > DB_CYCLES.
REQ-004 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: sw_raw  input  SW_W  raw board switches, asynchronous to clk, may bounce.
REQ-007 Port: sw  output  SW_W  debounced switch levels, registered; feeds the priority-encoder/segment stage (bit 8 = enable, bits 7:0 = request lines).
REQ-008 Port: sw_rise  output  SW_W  one-cycle pulse per bit when sw bit goes 0->1.
REQ-009 Port: sw_fall  output  SW_W  one-cycle pulse per bit when sw bit goes 1->0.
REQ-010 Port: sw_changed  output  1  one-cycle pulse when any sw bit changes on that edge.

Function
REQ-011 Each sw_raw bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-012 Each bit SHALL own an independent counter cnt[CNT_W-1:0] and stable level stb; sw[i] = stb[i].
REQ-013 On each edge where sync2[i] == stb[i]: cnt[i] <= 0, stb[i] unchanged.
REQ-014 On each edge where sync2[i] != stb[i] and cnt[i] < DB_CYCLES-1: cnt[i] <= cnt[i]+1.
REQ-015 On each edge where sync2[i] != stb[i] and cnt[i] == DB_CYCLES-1: stb[i] <= sync2[i], cnt[i] <= 0.
REQ-016 Latency: if sw_raw[i] is held at a new level from edge E onward, sw[i] SHALL take that level exactly at edge E+DB_CYCLES+1 and not earlier.
REQ-017 Glitch rejection: any sync2 excursion lasting fewer than DB_CYCLES cycles SHALL leave sw[i] unchanged and return cnt[i] to 0.
REQ-018 sw_rise[i]/sw_fall[i] SHALL be registered and asserted for exactly the one cycle following the edge on which stb[i] flips; never both in the same cycle.
REQ-019 sw_changed SHALL equal the OR of all sw_rise and sw_fall bits in the same cycle; simultaneous flips of several bits produce a single one-cycle pulse.
REQ-020 Counters SHALL never wrap; a counter cannot exceed DB_CYCLES-1.
REQ-021 Bits SHALL be fully independent; activity on one bit SHALL not alter another bit's counter or timing.

Reset
REQ-022 rst asserted SHALL immediately, without a clock, clear sync1, sync2, cnt, stb, sw, sw_rise, sw_fall and sw_changed to 0.
REQ-023 Reset mid-count SHALL discard the partial count; after release, a held-high input SHALL emerge at edge R+DB_CYCLES+1 (R = first edge after release), with an sw_rise pulse.
REQ-024 Deassertion SHALL not itself generate a pulse on any output.

Structure
REQ-025 SW_W, default DB_CYCLES and CNT_W SHALL live in shared package sw_pkg, also used by the encoder/segment stage.
REQ-026 Per-bit logic (synchronizer, counter, stb, edge pulses) SHALL be sub-module sw_debounce_bit, instantiated SW_W times by generate; sw_changed OR-reduction SHALL sit in the top.

Verification (DB_CYCLES = 4 for simulation)
REQ-027 Reset with sw_raw = 9'h1FF, release -> sw stays 0 until edge R+5, then sw = 9'h1FF, sw_rise = 9'h1FF and sw_changed = 1 for one cycle.
REQ-028 sw = 0; pulse sw_raw[3] high for 3 cycles -> sw, sw_rise and sw_changed stay 0 throughout.
REQ-029 sw = 9'h100; set sw_raw = 9'h180 at edge E -> sw = 9'h180 exactly at edge E+5, sw_rise = 9'h080 for one cycle.
REQ-030 sw = 9'h1FF; toggle sw_raw[0] every 2 cycles for 20 cycles, then hold 0 -> sw[0] falls exactly 5 edges after the final hold begins, with one sw_fall[0] pulse only.
REQ-031 sw_raw[1] rises at edge E, sw_raw[7] rises at E+2 -> sw_rise[1] pulses after E+5 and sw_rise[7] after E+7; sw_changed pulses twice.
REQ-032 Assert rst asynchronously with cnt[5] = 2 -> all outputs read 0 before the next clock edge; after release, a held-high sw_raw[5] is accepted at R+5.
